catc_sequencer: RTL and testbench

Program sequencer for the CATC execution unit. It holds a loadable 128×20 program store and a program counter. It fetches and issues one 20-bit instruction word every two cycles on the execution unit's `instr` and `data_in` inputs, and captures each result from the unit's `data_out`. It also interprets two control opcodes (JUMP, END) that the execution unit never sees, and forces NOP words between issues because the execution unit decodes every cycle.

---
 rtl/catc_pkg.sv | 30 +++
 rtl/catc_prog_mem.sv | 19 +
 rtl/catc_sequencer.sv | 106 ++++++++++
 tb/tb_catc_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/catc_pkg.sv
// catc_pkg: shared word width, opcodes, field positions and FSM states for the CATC sequencer
package catc_pkg;
  localparam int WIDTH = 20;
  localparam int ADDR_W = 7;
  localparam int DEPTH = 128;
  localparam int OP_LSB = 16;
  localparam int SRC_LSB = 12;
  localparam int DEST_LSB = 8;
  localparam int IMM_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W = 8;
  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;
  localparam logic [3:0] OP_NOT = 4'hD;
  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_END = 4'hF;
  localparam logic [WIDTH-1:0] NOP_WORD = 20'h80000;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/catc_prog_mem.sv
// catc_prog_mem: DEPTH x WIDTH single-port program RAM, synchronous write and read, no reset
// Ports: clk; we/addr/wdata write port; rdata = word at addr, registered (one-cycle read latency)
module catc_prog_mem #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/catc_sequencer.sv
// catc_sequencer: program sequencer feeding the CATC execution unit one word every two cycles
// Ports: clk, rst (async, active-high); prog_we/prog_addr/prog_wdata load the store while idle;
//   start/start_addr begin a run, halt aborts it; operand_in is sent with each issued word;
//   exec_result returns from the unit; instr/data_out/instr_valid drive the unit;
//   result/result_valid carry captured results; busy, done, pc, issue_count report status.
module catc_sequencer #(
  parameter int WIDTH = catc_pkg::WIDTH,
  parameter int ADDR_W = catc_pkg::ADDR_W,
  parameter int DEPTH = catc_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_wdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt,
  input  logic [WIDTH-1:0]  operand_in,
  input  logic [WIDTH-1:0]  exec_result,
  output logic [WIDTH-1:0]  instr,
  output logic [WIDTH-1:0]  data_out,
  output logic              instr_valid,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        issue_count
);
  import catc_pkg::*;
  state_t state;
  logic [WIDTH-1:0] word;
  logic [3:0] op;
  logic [1:0] pipe;
  // The single RAM port serves loading while idle and fetching at pc otherwise.
  catc_prog_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(prog_we && state == S_IDLE),
    .addr(state == S_IDLE ? prog_addr : pc),
    .wdata(prog_wdata),
    .rdata(word)
  );
  assign op = word[OP_LSB +: FIELD_W];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      instr <= NOP_WORD;
      data_out <= '0;
      instr_valid <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pc <= '0;
      issue_count <= '0;
      pipe <= '0;
    end else begin
      // The unit decodes every cycle, so anything not being issued is a NOP.
      instr <= NOP_WORD;
      instr_valid <= 1'b0;
      done <= 1'b0;
      if (halt) begin
        state <= S_IDLE;
        busy <= 1'b0;
        pipe <= '0;
        result_valid <= 1'b0;
      end else begin
        // Stage 2 lines up with the unit's two-cycle latency.
        pipe <= {pipe[0], instr_valid};
        result_valid <= pipe[1];
        if (pipe[1]) result <= exec_result;
        case (state)
          S_IDLE: if (start) begin
            state <= S_FETCH;
            busy <= 1'b1;
            pc <= start_addr;
            issue_count <= '0;
            pipe <= '0;
          end
          S_FETCH: state <= S_EXEC;
          S_EXEC: begin
            state <= op == OP_END ? S_DRAIN : S_FETCH;
            if (op == OP_JUMP) pc <= word[IMM_LSB +: ADDR_W];
            else if (op != OP_END) begin
              instr <= word;
              data_out <= operand_in;
              instr_valid <= 1'b1;
              pc <= pc + 1'b1;
              issue_count <= issue_count + {7'd0, issue_count != 8'hFF};
            end
          end
          S_DRAIN: if (pipe == 2'b00) begin
            state <= S_DONE;
            done <= 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_catc_sequencer.sv
// tb_catc_sequencer: scoreboard bench for catc_sequencer with a behavioural two-stage execution unit
module tb_catc_sequencer;
  import catc_pkg::*;
  typedef struct {
    logic [19:0] instr;
    logic [19:0] data;
    logic [19:0] res;
    int cyc;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_we = 1'b0;
  logic [6:0] prog_addr = '0;
  logic [19:0] prog_wdata = '0;
  logic start = 1'b0;
  logic [6:0] start_addr = '0;
  logic halt = 1'b0;
  logic [19:0] operand_in = '0;
  logic [19:0] exec_result;
  logic [19:0] instr, data_out, result;
  logic instr_valid, result_valid, busy, done;
  logic [6:0] pc;
  logic [7:0] issue_count;
  logic [19:0] s1 = '0, s2 = '0;
  int cyc = 0;
  int t0 = 0;
  int issued = 0;
  int n_checks = 0;
  int n_fail = 0;
  ent_t exp_q[$];
  ent_t res_q[$];
  ent_t e;
  catc_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .start(start), .start_addr(start_addr), .halt(halt), .operand_in(operand_in),
    .exec_result(exec_result), .instr(instr), .data_out(data_out), .instr_valid(instr_valid),
    .result(result), .result_valid(result_valid), .busy(busy), .done(done), .pc(pc),
    .issue_count(issue_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    s1 <= (instr[19:16] == 4'h2) ? data_out + {12'd0, instr[7:0]} : data_out;
    s2 <= s1;
  end
  assign exec_result = s2;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (instr_valid) begin
      if (exp_q.size() == 0) check("spurious_issue", 32'(instr), 32'(NOP_WORD));
      else begin
        e = exp_q.pop_front();
        check("issue_instr", 32'(instr), 32'(e.instr));
        check("issue_data", 32'(data_out), 32'(e.data));
        check("issue_cyc", 32'(cyc), 32'(e.cyc));
        e.cyc = cyc + 3;
        res_q.push_back(e);
        issued++;
      end
    end else check("nop_fill", 32'(instr), 32'(NOP_WORD));
    if (result_valid) begin
      if (res_q.size() == 0) check("spurious_result", 32'(result_valid), 32'(0));
      else begin
        e = res_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("result_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end
  task automatic load(input logic [6:0] a, input logic [19:0] w);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a;
    prog_wdata = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask
  task automatic run(input logic [6:0] a, input logic [19:0] opnd);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    operand_in = opnd;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask
  task automatic push(input logic [19:0] w, input logic [19:0] d, input logic [19:0] r, input int c);
    exp_q.push_back('{w, d, r, c});
  endtask
  task automatic wait_done(input int want_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("done_cyc", 32'(cyc), 32'(want_cyc));
      end
    end
    check("done_seen", 32'(seen), 32'(1));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'(0));
    check("done_pulse", 32'(done), 32'(0));
    check("exp_left", 32'(exp_q.size()), 32'(0));
    check("res_left", 32'(res_q.size()), 32'(0));
  endtask
  task automatic check_reset_vals();
    check("rst_instr", 32'(instr), 32'(NOP_WORD));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_issue_count", 32'(issue_count), 32'(0));
    check("rst_flags", 32'({instr_valid, result_valid, busy, done}), 32'(0));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    // load and run
    load(7'h00, 20'h21005);
    load(7'h01, 20'hF0000);
    run(7'h00, 20'd10);
    push(20'h21005, 20'd10, 20'd15, t0 + 2);
    wait_done(t0 + 6);
    check("run_issue_count", 32'(issue_count), 32'(1));
    check("run_pc", 32'(pc), 32'(1));
    // requests while busy are ignored
    run(7'h00, 20'd7);
    push(20'h21005, 20'd7, 20'd12, t0 + 2);
    @(negedge clk);
    check("busy_running", 32'(busy), 32'(1));
    prog_we = 1'b1;
    prog_addr = 7'h00;
    prog_wdata = 20'hF0000;
    start = 1'b1;
    start_addr = 7'h05;
    @(negedge clk);
    prog_we = 1'b0;
    start = 1'b0;
    wait_done(t0 + 6);
    run(7'h00, 20'd3);
    push(20'h21005, 20'd3, 20'd8, t0 + 2);
    wait_done(t0 + 6);
    // jump with wrap past 127
    load(7'h10, 20'hE007E);
    load(7'h7E, 20'h21001);
    load(7'h7F, 20'h21002);
    load(7'h00, 20'hF0000);
    run(7'h10, 20'd100);
    push(20'h21001, 20'd100, 20'd101, t0 + 4);
    push(20'h21002, 20'd100, 20'd102, t0 + 6);
    wait_done(t0 + 10);
    check("jump_pc", 32'(pc), 32'(0));
    check("jump_issue_count", 32'(issue_count), 32'(2));
    // halt together with start in idle
    @(negedge clk);
    start = 1'b1;
    halt = 1'b1;
    start_addr = 7'h10;
    @(posedge clk);
    #1 start = 1'b0;
    halt = 1'b0;
    check("halt_beats_start", 32'(busy), 32'(0));
    // halt out of an endless jump-to-self
    load(7'h20, 20'hE0020);
    run(7'h20, 20'd5);
    repeat (9) @(negedge clk);
    check("loop_busy", 32'(busy), 32'(1));
    halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    check("halt_busy", 32'(busy), 32'(0));
    check("halt_done", 32'(done), 32'(0));
    check("halt_result_valid", 32'(result_valid), 32'(0));
    check("halt_pc", 32'(pc), 32'(7'h20));
    check("halt_issue_count", 32'(issue_count), 32'(0));
    run(7'h7E, 20'd50);
    push(20'h21001, 20'd50, 20'd51, t0 + 2);
    push(20'h21002, 20'd50, 20'd52, t0 + 4);
    wait_done(t0 + 8);
    // issue count saturation
    load(7'h30, 20'h21001);
    load(7'h31, 20'hE0030);
    run(7'h30, 20'd0);
    for (int i = 0; i < 300; i++) push(20'h21001, 20'd0, 20'd1, t0 + 2 + 4 * i);
    begin
      int target = issued + 300;
      int n = 0;
      while (issued < target && n < 2000) begin
        @(negedge clk);
        #1 n++;
      end
      check("sat_reached", 32'(issued >= target), 32'(1));
    end
    halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    exp_q.delete();
    res_q.delete();
    check("sat_issue_count", 32'(issue_count), 32'(255));
    check("sat_busy", 32'(busy), 32'(0));
    repeat (4) @(negedge clk);
    // async reset in the middle of EXEC
    run(7'h7E, 20'd9);
    @(posedge clk);
    #2 check("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    run(7'h7E, 20'd1);
    push(20'h21001, 20'd1, 20'd2, t0 + 2);
    push(20'h21002, 20'd1, 20'd3, t0 + 4);
    wait_done(t0 + 8);
    check("final_issue_count", 32'(issue_count), 32'(2));
    check("final_pc", 32'(pc), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
